// File: rtl/contador_mod10_if.sv
// contador_mod10_if -- signal bundle for the BCD down-counter decade.
//
// Groups the control/preset inputs and the count/status outputs of one
// contador_mod10 decade so that a driver (master) and the counter side
// (slave) can be passed around as a single object. The counter keeps its
// flat port list, so a bench or parent wires these fields to it by name.
//
//   data      [3:0]  BCD preset value (0-9 meaningful)
//   load             synchronous parallel load, active-low
//   en               count enable, active-high
//   count     [3:0]  current BCD digit
//   tc               borrow to the next decade (count==0 && en)
//   count_end        zero-detect flag (count==0)
interface contador_mod10_if;
  logic [3:0] data;
  logic       load;
  logic       en;
  logic [3:0] count;
  logic       tc;
  logic       count_end;

  modport master (output data, load, en, input  count, tc, count_end);
  modport slave  (input  data, load, en, output count, tc, count_end);
endinterface

// File: rtl/contador_mod10.sv
// contador_mod10 -- modulo-10 (BCD) down counter, one decade.
//
// Counts 9,8,...,1,0,9,... on rising clk edges while en=1. A low load
// preloads data on the edge regardless of en. clearn clears the count to 0
// asynchronously. tc is the borrow into the next decade and is high for the
// cycle in which the wrap 0->9 happens; count_end flags count==0.
//
// Ports (in order):
//   data      in  [3:0]  BCD preset value
//   clk       in         clock, rising edge
//   load      in         synchronous load, active-low (beats en)
//   en        in         count enable, active-high
//   clearn    in         asynchronous clear, active-low (beats everything)
//   count     out [3:0]  registered BCD digit
//   tc        out        combinational borrow: count==0 && en
//   count_end out        combinational zero detect: count==0
//
// Build option:
//   CONTADOR_MOD10_LOAD_CLAMP_EN  when defined, preset values 10-15 are
//   stored as 9 so the counter can never leave the BCD range. Without it
//   data is stored as given; an out-of-range value just counts down by one
//   per edge until it reaches 0 and rejoins the normal 9..0 cycle.
module contador_mod10 (
  input  logic [3:0] data,
  input  logic       clk,
  input  logic       load,
  input  logic       en,
  input  logic       clearn,
  output logic [3:0] count,
  output logic       tc,
  output logic       count_end
);

  logic [3:0] load_val;
  logic [3:0] dec_val;
  logic [3:0] count_nxt;
  logic       is_zero;

`ifdef CONTADOR_MOD10_LOAD_CLAMP_EN
  assign load_val = (data > 4'd9) ? 4'd9 : data;
`else
  assign load_val = data;
`endif

  assign is_zero = (count == 4'd0);

  // Plain decrement also covers the 10-15 range; only 0 wraps.
  assign dec_val = is_zero ? 4'd9 : (count - 4'd1);

  // load > en > hold
  always_comb begin
    count_nxt = count;
    if (!load)   count_nxt = load_val;
    else if (en) count_nxt = dec_val;
  end

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) count <= 4'd0;
    else         count <= count_nxt;
  end

  assign count_end = is_zero;
  assign tc        = is_zero & en;

endmodule

// File: tb/tb_contador_mod10.sv
// tb_contador_mod10 -- self-checking bench for contador_mod10.
// Directed vector table, hand-written reset sequences, then random stimulus
// against a behavioural model of the decade counter.
module tb_contador_mod10;

  logic clk;
  logic clearn;
  int   ntests;
  int   nfail;

  contador_mod10_if bus ();

  contador_mod10 dut (
    .data      (bus.data),
    .clk       (clk),
    .load      (bus.load),
    .en        (bus.en),
    .clearn    (clearn),
    .count     (bus.count),
    .tc        (bus.tc),
    .count_end (bus.count_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Value the counter should store when loading d.
  function automatic int load_ref(int d);
`ifdef CONTADOR_MOD10_LOAD_CLAMP_EN
    return (d > 9) ? 9 : d;
`else
    return d;
`endif
  endfunction

  // Next digit after one edge, straight from the counting rules.
  function automatic int next_ref(int m, bit ld_n, bit e, int d);
    if (!ld_n) return load_ref(d);
    if (!e)    return m;
    if (m == 0) return 9;
    return m - 1;
  endfunction

  task automatic check(string name, int got, int exp);
    ntests++;
    if (got != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Compare all three outputs against a model count and the applied en.
  task automatic check_all(string name, int m);
    check({name, ".count"},     int'(bus.count),     m);
    check({name, ".count_end"}, int'(bus.count_end), (m == 0) ? 1 : 0);
    check({name, ".tc"},        int'(bus.tc),        (m == 0 && bus.en) ? 1 : 0);
  endtask

  typedef struct {
    bit       load;
    bit       en;
    int       data;
    int       exp_count;
    bit       exp_tc;
    bit       exp_ce;
  } vec_t;

`ifdef CONTADOR_MOD10_LOAD_CLAMP_EN
  localparam int OOR_LD  = 9;
  localparam int OOR_DEC = 8;
`else
  localparam int OOR_LD  = 12;
  localparam int OOR_DEC = 11;
`endif

  initial begin
    vec_t vecs[$];
    int   m;
    ntests = 0;
    nfail  = 0;

    // ---- reset with clock edges pending but load/en active ----
    clearn   = 1'b0;
    bus.data = 4'd7;
    bus.load = 1'b0;
    bus.en   = 1'b0;
    #1;
    check("rst.count", int'(bus.count), 0);
    check("rst.count_end", int'(bus.count_end), 1);
    check("rst.tc_en0", int'(bus.tc), 0);
    bus.en = 1'b1;
    #1;
    check("rst.tc_en1", int'(bus.tc), 1);
    // load/en ignored across edges while clear is held
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst.hold_ignores_load", int'(bus.count), 0);
    bus.en = 1'b0;
    bus.load = 1'b1;
    clearn = 1'b1;

    // ---- directed table, starting from count=0 ----
    vecs.push_back('{1'b0, 1'b0, 6,  6, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 0,  6, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 0,  5, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 0,  4, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 0,  3, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 0,  2, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 0,  1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 0,  0, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 0,  9, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 0,  9, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 3,  3, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 8,  8, 1'b0, 1'b0});   // load beats en
    vecs.push_back('{1'b1, 1'b0, 0,  8, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 0,  0, 1'b0, 1'b1});   // zero, en=0 -> no tc
    vecs.push_back('{1'b0, 1'b0, 12, OOR_LD, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 0,  OOR_DEC, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 15, OOR_LD + 3 - 3 + ((OOR_LD == 12) ? 3 : 0), 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 0,  OOR_DEC + ((OOR_LD == 12) ? 3 : 0), 1'b0, 1'b0});

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      bus.load = vecs[i].load;
      bus.en   = vecs[i].en;
      bus.data = 4'(vecs[i].data);
      @(posedge clk); #1;
      check($sformatf("vec%0d.count", i), int'(bus.count), vecs[i].exp_count);
      check($sformatf("vec%0d.tc", i), int'(bus.tc), int'(vecs[i].exp_tc));
      check($sformatf("vec%0d.count_end", i), int'(bus.count_end), int'(vecs[i].exp_ce));
    end

    // ---- async clear mid-count, then resume at 9 ----
    bus.load = 1'b0; bus.en = 1'b1; bus.data = 4'd5;
    @(posedge clk); #1;
    bus.load = 1'b1;
    check("abort.pre", int'(bus.count), 5);
    #2 clearn = 1'b0;
    #1;
    check("abort.async_count", int'(bus.count), 0);
    check("abort.tc", int'(bus.tc), 1);
    #1 clearn = 1'b1;
    @(posedge clk); #1;
    check("abort.first_edge", int'(bus.count), 9);

    // ---- random stimulus vs model ----
    m = 9;
    for (int i = 0; i < 400; i++) begin
      bus.load = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
      bus.en   = 1'($urandom_range(0, 1));
      bus.data = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 24) == 0) begin
        clearn = 1'b0;
        m = 0;
        #1;
        check($sformatf("rnd%0d.async_clr", i), int'(bus.count), 0);
      end else begin
        clearn = 1'b1;
      end
      @(posedge clk);
      if (clearn) m = next_ref(m, bus.load, bus.en, int'(bus.data));
      #1;
      check_all($sformatf("rnd%0d", i), m);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  // Hard time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, limit 200000");
    $fatal(1, "timeout");
  end

endmodule
